// File: rtl/barrett_arbiter.sv
// barrett_arbiter
//
// Purpose:
//   Shares one combinational Barrett reducer (32-bit c in, c mod 3329 out)
//   among NUM_REQ requesters. Operands are picked round-robin, pass through
//   two registered stages and come back tagged with the requester index.
//   The unit sustains one reduction per clock when the consumer never stalls.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_valid   per-requester operand valid
//   req_data    operand c, requester i on bits [32*i+31:32*i]
//   req_ready   per-requester accept, one-hot or zero
//   resp_valid  result valid
//   resp_ready  downstream accepts the result
//   resp_data   reduced value 0..3328, bits [15:12] always zero
//   resp_id     requester index that issued the operand behind resp_data
//   busy        high while either pipeline stage holds valid data

module barrett_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [15:0]             resp_data,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy
);

    localparam logic [31:0] MODULUS   = 32'd3329;
    localparam logic [13:0] MOD_X1    = 14'd3329;
    localparam logic [13:0] MOD_X2    = 14'd6658;
    localparam logic [52:0] BARRETT_M = 53'd1290167;

    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_c_q,     s1_c_d;
    logic [ID_W-1:0] s1_id_q,    s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [11:0]     s2_data_q,  s2_data_d;
    logic [ID_W-1:0] s2_id_q,    s2_id_d;
    logic [ID_W-1:0] ptr_q,      ptr_d;

    logic            s2_load;
    logic            s1_free;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            accept;
    logic [31:0]     req_word [NUM_REQ];

    logic [20:0]     red_q;
    logic [13:0]     red_r;
    logic [11:0]     red_val;

    // Barrett reduction of the operand sitting in stage s1. M is
    // floor(2^32 / 3329), so the quotient estimate can only be low, never
    // high, and the partial remainder stays below 3*3329. Two conditional
    // subtractions bring it into 0..3328; only the low 14 bits of the
    // partial remainder are ever non-zero, so the rest are dropped.
    always_comb begin
        red_q   = 21'((53'(s1_c_q) * BARRETT_M) >> 32);
        red_r   = 14'(s1_c_q - 32'(red_q) * MODULUS);
        red_val = 12'(red_r);
        if (red_r >= MOD_X2) begin
            red_val = 12'(red_r - MOD_X2);
        end else if (red_r >= MOD_X1) begin
            red_val = 12'(red_r - MOD_X1);
        end
    end

    // Unpack the flat operand bus into one word per requester so the
    // granted operand can be picked with a plain index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_word[i] = req_data[32*i +: 32];
        end
    end

    // Round-robin search: start one past the last granted requester and walk
    // upwards with wrap-around; the first requester found valid wins. Because
    // the winner becomes the new pointer, it drops to lowest priority next
    // time, which bounds every requester's wait to NUM_REQ-1 handshakes.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Pipeline advance and accept. s2 takes s1's contents whenever s2 is
    // empty or being drained this cycle, and s1 may refill in that same
    // cycle, which is what lets a continuous stream run at one per clock.
    // When the consumer stalls with both stages full, s1 cannot move and the
    // grant is withheld, so nothing is dropped or overwritten.
    always_comb begin
        s2_load   = s1_valid_q && (!s2_valid_q || resp_ready);
        s1_free   = !s1_valid_q || s2_load;
        accept    = grant_found && s1_free && !rst;
        req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

        s1_valid_d = s1_valid_q;
        s1_c_d     = s1_c_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        ptr_d      = ptr_q;

        if (!s2_valid_q || resp_ready) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_data_d  = red_val;
            s2_id_d    = s1_id_q;
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_c_d     = req_word[grant_idx];
            s1_id_d    = grant_idx;
            ptr_d      = grant_idx;
        end
    end

    // State registers. Reset empties both stages, clears the captured data
    // and parks the pointer on the last requester so requester 0 is
    // searched first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_c_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_c_q     <= s1_c_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            ptr_q      <= ptr_d;
        end
    end

    // Stage s2 drives the response channel directly.
    always_comb begin
        resp_valid = s2_valid_q;
        resp_data  = {4'b0000, s2_data_q};
        resp_id    = s2_id_q;
        busy       = s1_valid_q || s2_valid_q;
    end

endmodule

// File: tb/tb_barrett_arbiter.sv
// tb_barrett_arbiter
//
// Purpose:
//   Self-checking bench for barrett_arbiter with four requesters. Directed
//   scenarios cover reset, latency, back-to-back streaming, round-robin
//   fairness, backpressure and mid-flight reset; a randomized run checks
//   every response against c % 3329 using an ordered in-flight model.
//
// Ports: none (top-level bench).

module tb_barrett_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [15:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] val;
        int          id;
        int          acc;
    } item_t;

    barrett_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the DUT locks up.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one full cycle, ending on the falling edge where inputs change.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Two reset cycles with all requests idle, ending just after a negedge.
    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Outputs while reset is held, including req_ready suppression.
    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_data   = {$urandom, $urandom, $urandom, $urandom};
        resp_ready = 1'b1;
        tick();
        tick();
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready);
        end
        tests_run++;
        if ({resp_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid_busy: got %b want 00", {resp_valid, busy});
        end
        tests_run++;
        if ({resp_id, resp_data} !== 18'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data_id: got id %0d data %h want id 0 data 0000", resp_id, resp_data);
        end
        rst       = 1'b0;
        req_valid = '0;
        tick();
    endtask

    // Single operand 0xFFFFFFFF from requester 0; result 1352 two edges later.
    task automatic test_first();
        do_reset();
        req_valid       = 4'b0001;
        req_data[31:0]  = 32'hFFFF_FFFF;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL first_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        tests_run++;
        if ({resp_valid, busy} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL first_stage1: got valid/busy %b want 01", {resp_valid, busy});
        end
        tick();
        #1;
        tests_run++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd0, 16'h0548}) begin
            tests_failed++;
            $display("[TB] FAIL first_resp: got v %b id %0d data %h want v 1 id 0 data 0548", resp_valid, resp_id, resp_data);
        end
        tick();
        #1;
        tests_run++;
        if ({resp_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL first_drain: got valid/busy %b want 00", {resp_valid, busy});
        end
    endtask

    // Four operands streamed by requester 0 with no gaps in or out.
    task automatic test_back_to_back();
        logic [31:0] ops [4];
        logic [15:0] exp [4];
        ops = '{32'd3328, 32'd3329, 32'd6658, 32'h0001_0000};
        exp = '{16'h0D00, 16'h0000, 16'h0000, 16'h08ED};
        do_reset();
        for (int cyc = 0; cyc <= 6; cyc++) begin
            if (cyc < 4) begin
                req_valid      = 4'b0001;
                req_data[31:0] = ops[cyc];
            end else begin
                req_valid = '0;
            end
            #1;
            if (cyc < 4) begin
                tests_run++;
                if (req_ready !== 4'b0001) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_ready[%0d]: got %b want 0001", cyc, req_ready);
                end
            end
            if (cyc >= 2 && cyc <= 5) begin
                tests_run++;
                if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd0, exp[cyc-2]}) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_resp[%0d]: got v %b id %0d data %h want v 1 id 0 data %h", cyc - 2, resp_valid, resp_id, resp_data, exp[cyc-2]);
                end
            end
            if (cyc == 6) begin
                tests_run++;
                if (resp_valid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_tail: got resp_valid %b want 0", resp_valid);
                end
            end
            tick();
        end
    endtask

    // All requesters continuously valid: grants must rotate 0,1,2,3,...
    task automatic test_fairness();
        logic [31:0] ops [NUM_REQ];
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            ops[i] = $urandom ^ (32'h1111_1111 * i);
            req_data[32*i +: 32] = ops[i];
        end
        for (int n = 0; n < 10; n++) begin
            req_valid = (n < 8) ? 4'hF : 4'h0;
            #1;
            if (n < 8) begin
                tests_run++;
                if (req_ready !== 4'(1 << (n % NUM_REQ))) begin
                    tests_failed++;
                    $display("[TB] FAIL fair_grant[%0d]: got %b want %b", n, req_ready, 4'(1 << (n % NUM_REQ)));
                end
            end
            if (n >= 2) begin
                tests_run++;
                if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'((n - 2) % NUM_REQ), 16'(ops[(n-2) % NUM_REQ] % 32'd3329)}) begin
                    tests_failed++;
                    $display("[TB] FAIL fair_resp[%0d]: got v %b id %0d data %h want v 1 id %0d data %h", n - 2, resp_valid, resp_id, resp_data, (n - 2) % NUM_REQ, 16'(ops[(n-2) % NUM_REQ] % 32'd3329));
                end
            end
            tick();
        end
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fair_idle: got busy %b want 0", busy);
        end
    endtask

    // Consumer stalls five cycles with three operands offered.
    task automatic test_backpressure();
        logic [31:0] ops [3];
        logic [15:0] exp [3];
        do_reset();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ops[i] = $urandom;
            exp[i] = 16'(ops[i] % 32'd3329);
            req_data[32*i +: 32] = ops[i];
        end
        req_valid = 4'b0111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL bp_accept0: got %b want 0001", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL bp_accept1: got %b want 0010", req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            #1;
            tests_run++;
            if ({req_ready, resp_valid, resp_id, resp_data} !== {4'b0000, 1'b1, 2'd0, exp[0]}) begin
                tests_failed++;
                $display("[TB] FAIL bp_stall[%0d]: got ready %b v %b id %0d data %h want ready 0000 v 1 id 0 data %h", c, req_ready, resp_valid, resp_id, resp_data, exp[0]);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        tests_run++;
        if ({req_ready, resp_valid, resp_id, resp_data} !== {4'b0100, 1'b1, 2'd0, exp[0]}) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: got ready %b v %b id %0d data %h want ready 0100 v 1 id 0 data %h", req_ready, resp_valid, resp_id, resp_data, exp[0]);
        end
        tick();
        req_valid[2] = 1'b0;
        for (int r = 1; r < 3; r++) begin
            #1;
            tests_run++;
            if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'(r), exp[r]}) begin
                tests_failed++;
                $display("[TB] FAIL bp_drain[%0d]: got v %b id %0d data %h want v 1 id %0d data %h", r, resp_valid, resp_id, resp_data, r, exp[r]);
            end
            tick();
        end
        #1;
        tests_run++;
        if ({resp_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL bp_empty: got valid/busy %b want 00", {resp_valid, busy});
        end
    endtask

    // Reset while both stages are full must flush everything.
    task automatic test_reset_mid();
        do_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b0001;
        req_data   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        #1;
        tests_run++;
        if ({resp_valid, busy} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL mid_full: got valid/busy %b want 11", {resp_valid, busy});
        end
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL mid_rst_ready: got %b want 0000", req_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({resp_valid, busy, resp_id, resp_data} !== 20'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_flush: got v %b busy %b id %0d data %h want all zero", resp_valid, busy, resp_id, resp_data);
        end
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL mid_ptr: got %b want 0001", req_ready);
        end
        do_reset();
    endtask

    // Random traffic against an ordered in-flight model: the pipeline holds at
    // most two operands, the oldest reaches the output two edges after its
    // acceptance, space opens when the output drains, and grants follow
    // round-robin order after the last winner.
    task automatic test_random();
        item_t       flight [$];
        item_t       it;
        bit          pending [NUM_REQ];
        logic [3:0]  exp_ready;
        logic        exp_rv;
        int          m_ptr;
        int          g;
        int          cyc;
        int          issued;
        int          accepted;
        int          responses;
        do_reset();
        m_ptr     = NUM_REQ - 1;
        cyc       = 0;
        issued    = 0;
        accepted  = 0;
        responses = 0;
        for (int i = 0; i < NUM_REQ; i++) pending[i] = 1'b0;
        while ((accepted < 1000 || flight.size() > 0) && cyc < 20000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pending[i] && issued < 1000 && $urandom_range(1, 0) == 1) begin
                    pending[i] = 1'b1;
                    req_data[32*i +: 32] = $urandom;
                    issued++;
                end
                req_valid[i] = pending[i];
            end
            resp_ready = (accepted >= 1000) ? 1'b1 : ($urandom_range(9, 0) < 7);
            #1;
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int j;
                j = (m_ptr + k) % NUM_REQ;
                if (g < 0 && pending[j]) g = j;
            end
            exp_ready = (g >= 0 && (flight.size() < 2 || resp_ready)) ? 4'(1 << g) : 4'b0000;
            exp_rv    = (flight.size() > 0) && (cyc >= flight[0].acc + 2);
            tests_run++;
            if (req_ready !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL rand_ready[cyc %0d]: got %b want %b", cyc, req_ready, exp_ready);
            end
            tests_run++;
            if (resp_valid !== exp_rv) begin
                tests_failed++;
                $display("[TB] FAIL rand_valid[cyc %0d]: got %b want %b", cyc, resp_valid, exp_rv);
            end
            if (exp_rv) begin
                tests_run++;
                if ({resp_id, resp_data} !== {2'(flight[0].id), flight[0].val}) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_resp[cyc %0d]: got id %0d data %h want id %0d data %h", cyc, resp_id, resp_data, flight[0].id, flight[0].val);
                end
                if (resp_ready) begin
                    void'(flight.pop_front());
                    responses++;
                end
            end
            if (exp_ready != 4'b0000) begin
                it.val = 16'(req_data[32*g +: 32] % 32'd3329);
                it.id  = g;
                it.acc = cyc;
                flight.push_back(it);
                pending[g] = 1'b0;
                m_ptr      = g;
                accepted++;
            end
            tick();
            cyc++;
        end
        req_valid = '0;
        tests_run++;
        if (cyc >= 20000) begin
            tests_failed++;
            $display("[TB] FAIL rand_timeout: got %0d cycles want under 20000", cyc);
        end
        tests_run++;
        if (accepted != 1000 || responses != accepted) begin
            tests_failed++;
            $display("[TB] FAIL rand_counts: got %0d accepted %0d responses want 1000 and 1000", accepted, responses);
        end
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rand_idle: got busy %b want 0", busy);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        test_reset();
        test_first();
        test_back_to_back();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
